// File: rtl/ifetch_buf.sv
// rtl/ifetch_buf.sv - instruction fetch buffer between the PC and decode
module ifetch_buf #(
    parameter int          DEPTH      = 2,
    parameter int          AW         = 16,
    parameter int          DW         = 16,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] iaddr,
    output logic          hlt,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic          halted
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            halted_q, halted_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   fifo_pc_q   [DEPTH];
    logic [AW-1:0]   fifo_pc_d   [DEPTH];
    logic [DW-1:0]   fifo_data_q [DEPTH];
    logic [DW-1:0]   fifo_data_d [DEPTH];

    logic            push;
    logic            pop;
    logic            is_hlt;

    // A full FIFO never requests, even if decode pops this same cycle.
    assign mem_req     = (state_q == FETCH) && (count_q != FULL) && !rst;
    assign mem_addr    = iaddr;
    assign push        = mem_req && mem_ack;
    assign is_hlt      = (mem_rdata[DW-1 -: 4] == HLT_OPCODE);
    // The PC only advances on a completed non-HLT fetch, so it rests on the HLT address.
    assign hlt         = !push || is_hlt;
    assign instr_valid = (count_q != '0) && !rst;
    assign pop         = instr_valid && instr_ready;
    assign instr       = fifo_data_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];
    assign halted      = halted_q;

    // Next-state for FSM, pointers, occupancy and FIFO storage.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_data_d = fifo_data_q;

        if (push) begin
            fifo_pc_d[wr_ptr_q]   = iaddr;
            fifo_data_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if ((state_q == FETCH) && push && is_hlt) begin
            state_d = HALTED;
        end
        halted_d = (state_d == HALTED);
    end

    // Control state with synchronous reset; a late ack during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            halted_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO payload storage needs no reset; occupancy tracking qualifies it.
    always_ff @(posedge clk) begin
        fifo_pc_q   <= fifo_pc_d;
        fifo_data_q <= fifo_data_d;
    end

endmodule

// File: tb/tb_ifetch_buf.sv
// tb/tb_ifetch_buf.sv - self-checking bench for ifetch_buf
module tb_ifetch_buf;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic [15:0] iaddr;
    logic        hlt;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;

    ifetch_buf #(.DEPTH(DEPTH), .AW(16), .DW(16), .HLT_OPCODE(4'hF)) dut (
        .clk(clk), .rst(rst), .iaddr(iaddr), .hlt(hlt),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] d;
    } ent_t;

    ent_t        sb[$];
    ent_t        exp_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] pc;
    logic [15:0] cur_data;
    int          cnt_m;
    bit          halted_m;
    bit          use_img;
    bit          exp_req, exp_fire, exp_hlt, exp_valid, exp_pop;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        if (use_img && a == 16'd3) return 16'h3000;
        if (use_img && a == 16'd4) return 16'hF000;
        return a;
    endfunction

    // Drive one cycle of inputs and compute model expectations, then settle.
    task automatic apply(input bit r, input bit a, input bit rd);
        rst         = r;
        mem_ack     = a;
        instr_ready = rd;
        iaddr       = pc;
        cur_data    = mem_fn(pc);
        mem_rdata   = cur_data;
        exp_req     = !r && !halted_m && (cnt_m < DEPTH);
        exp_fire    = exp_req && a;
        exp_hlt     = !exp_fire || (cur_data[15:12] == 4'hF);
        exp_valid   = !r && (cnt_m > 0);
        exp_pop     = exp_valid && rd;
        if (exp_pop) exp_e = sb.pop_front();
        #3;
    endtask

    // Advance the model (FIFO occupancy, halt, PC) and the clock.
    task automatic tick();
        if (rst) begin
            cnt_m    = 0;
            halted_m = 1'b0;
            sb.delete();
            pc       = 16'd0;
        end else begin
            if (exp_fire) begin
                sb.push_back('{pc: pc, d: cur_data});
                if (cur_data[15:12] == 4'hF) halted_m = 1'b1;
            end
            cnt_m = cnt_m + int'(exp_fire) - int'(exp_pop);
            if (!exp_hlt) pc = pc + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (mem_req !== 1'b0 || hlt !== 1'b1 || instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: got req=%b hlt=%b valid=%b want 0 1 0", mem_req, hlt, instr_valid);
            end
            tick();
        end
        apply(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (halted !== 1'b0 || instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_after: got halted=%b valid=%b req=%b addr=%h want 0 0 1 0000", halted, instr_valid, mem_req, mem_addr);
        end
        tick();
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (hlt !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'(i)) begin
                n_fail++;
                $display("FAIL zw_fetch[%0d]: got hlt=%b req=%b addr=%h want 0 1 %h", i, hlt, mem_req, mem_addr, 16'(i));
            end
            n_cmp++;
            if (instr_valid !== (i > 0)) begin
                n_fail++;
                $display("FAIL zw_valid[%0d]: got %b want %b", i, instr_valid, (i > 0));
            end
            if (exp_pop) begin
                n_cmp++;
                if (instr_pc !== 16'(i - 1) || instr !== exp_e.d) begin
                    n_fail++;
                    $display("FAIL zw_pop[%0d]: got pc=%h instr=%h want pc=%h instr=%h", i, instr_pc, instr, 16'(i - 1), exp_e.d);
                end
            end
            tick();
        end
    endtask

    task automatic test_delayed_ack();
        logic [15:0] a0;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            a0 = pc;
            for (int w = 0; w < 3; w++) begin
                apply(1'b0, 1'b0, 1'b1);
                n_cmp++;
                if (hlt !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 16'(f)) begin
                    n_fail++;
                    $display("FAIL dly_wait[%0d.%0d]: got hlt=%b req=%b addr=%h want 1 1 %h", f, w, hlt, mem_req, mem_addr, 16'(f));
                end
                if (exp_pop) begin
                    n_cmp++;
                    if (instr_pc !== exp_e.pc || instr !== exp_e.d) begin
                        n_fail++;
                        $display("FAIL dly_pop: got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp_e.pc, exp_e.d);
                    end
                end
                tick();
            end
            apply(1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (hlt !== 1'b0 || mem_addr !== a0) begin
                n_fail++;
                $display("FAIL dly_ack[%0d]: got hlt=%b addr=%h want 0 %h", f, hlt, mem_addr, a0);
            end
            tick();
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (mem_req !== 1'b1 || hlt !== 1'b0) begin
                n_fail++;
                $display("FAIL full_fill[%0d]: got req=%b hlt=%b want 1 0", i, mem_req, hlt);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (mem_req !== 1'b0 || hlt !== 1'b1 || instr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL full_stall[%0d]: got req=%b hlt=%b valid=%b want 0 1 1", i, mem_req, hlt, instr_valid);
            end
            tick();
        end
        apply(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (mem_req !== 1'b0 || instr_pc !== 16'd0 || instr !== exp_e.d) begin
            n_fail++;
            $display("FAIL full_pop: got req=%b pc=%h instr=%h want 0 0000 %h", mem_req, instr_pc, instr, exp_e.d);
        end
        tick();
        apply(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 16'd2 || hlt !== 1'b0) begin
            n_fail++;
            $display("FAIL full_resume: got req=%b addr=%h hlt=%b want 1 0002 0", mem_req, mem_addr, hlt);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, 1'b1);
            if (exp_pop) begin
                n_cmp++;
                if (instr_pc !== exp_e.pc || instr !== exp_e.d) begin
                    n_fail++;
                    $display("FAIL full_drain: got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp_e.pc, exp_e.d);
                end
            end
            tick();
        end
    endtask

    task automatic test_halt();
        logic [15:0] last;
        last    = 16'h0;
        use_img = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (hlt !== exp_hlt || mem_req !== exp_req || halted !== halted_m) begin
                n_fail++;
                $display("FAIL halt_cyc[%0d]: got hlt=%b req=%b halted=%b want %b %b %b", i, hlt, mem_req, halted, exp_hlt, exp_req, halted_m);
            end
            if (i >= 4) begin
                n_cmp++;
                if (hlt !== 1'b1 || mem_addr !== 16'd4 || halted !== (i >= 5)) begin
                    n_fail++;
                    $display("FAIL halt_hold[%0d]: got hlt=%b addr=%h halted=%b want 1 0004 %b", i, hlt, mem_addr, halted, (i >= 5));
                end
            end
            if (exp_pop) begin
                n_cmp++;
                if (instr_pc !== exp_e.pc || instr !== exp_e.d) begin
                    n_fail++;
                    $display("FAIL halt_pop: got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp_e.pc, exp_e.d);
                end
                last = instr;
            end
            tick();
        end
        apply(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (last !== 16'hF000 || instr_valid !== 1'b0 || halted !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_end: got last=%h valid=%b halted=%b req=%b want F000 0 1 0", last, instr_valid, halted, mem_req);
        end
        tick();
        use_img = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(1'b0, 1'b1, 1'b0);
        tick();
        apply(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (mem_req !== 1'b1 || hlt !== 1'b1 || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pending: got req=%b hlt=%b valid=%b want 1 1 1", mem_req, hlt, instr_valid);
        end
        tick();
        apply(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (mem_req !== 1'b0 || hlt !== 1'b1 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_inrst: got req=%b hlt=%b valid=%b want 0 1 0", mem_req, hlt, instr_valid);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (instr_valid !== 1'b0 || halted !== 1'b0 || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_after: got valid=%b halted=%b req=%b want 0 0 1", instr_valid, halted, mem_req);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b1);
            if (exp_pop) begin
                n_cmp++;
                if (instr_pc !== 16'(i - 1) || instr !== exp_e.d) begin
                    n_fail++;
                    $display("FAIL rmid_pop[%0d]: got pc=%h instr=%h want pc=%h instr=%h", i, instr_pc, instr, 16'(i - 1), exp_e.d);
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        int fires;
        int pops;
        fires = 0;
        pops  = 0;
        do_reset();
        for (int cyc = 0; cyc < 60 && pops < 10; cyc++) begin
            apply(1'b0, (fires < 10), (cyc % 2 == 0));
            if (exp_pop) begin
                n_cmp++;
                if (instr_pc !== 16'(pops) || instr !== exp_e.d) begin
                    n_fail++;
                    $display("FAIL wrap_pop[%0d]: got pc=%h instr=%h want pc=%h instr=%h", pops, instr_pc, instr, 16'(pops), exp_e.d);
                end
                pops++;
            end
            if (exp_fire) fires++;
            tick();
        end
        apply(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (pops != 10 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_count: got pops=%0d valid=%b want 10 0", pops, instr_valid);
        end
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        iaddr       = 16'd0;
        mem_rdata   = 16'd0;
        pc          = 16'd0;
        cnt_m       = 0;
        halted_m    = 1'b0;
        use_img     = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_full();
        test_halt();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
